// File: rtl/pipe_stage_regs.sv
// Inter-stage latch bank for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB),
// with its own data-cache stall, sticky halt and saturating stall-cycle counter.
module pipe_stage_regs #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              flush_ID,
    input  logic              flush_EX,
    input  logic              flush_MEM,
    input  logic              enable_ID,
    input  logic              enable_EX,
    input  logic              enable_MEM,
    input  logic [WORD_W-1:0] instr_IF,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic [DATA_W-1:0] data_ID,
    input  logic [WORD_W-1:0] result_EX,
    input  logic [WORD_W-1:0] dmemload_MEM,
    output logic [WORD_W-1:0] instr_ID,
    output logic [WORD_W-1:0] instr_EX,
    output logic [WORD_W-1:0] instr_MEM,
    output logic [WORD_W-1:0] instr_WB,
    output logic [CTRL_W-1:0] ctrl_EX,
    output logic [CTRL_W-1:0] ctrl_MEM,
    output logic [CTRL_W-1:0] ctrl_WB,
    output logic [DATA_W-1:0] data_EX,
    output logic [WORD_W-1:0] result_MEM,
    output logic [WORD_W-1:0] result_WB,
    output logic [WORD_W-1:0] dmemload_WB,
    output logic              RegWr_EX,
    output logic              memWr_EX,
    output logic              RegWr_MEM,
    output logic              memWr_MEM,
    output logic              mem_stall,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic [WORD_W-1:0] r_instr_id;
    logic [WORD_W-1:0] r_instr_ex;
    logic [CTRL_W-1:0] r_ctrl_ex;
    logic [DATA_W-1:0] r_data_ex;
    logic [WORD_W-1:0] r_instr_mem;
    logic [CTRL_W-1:0] r_ctrl_mem;
    logic [WORD_W-1:0] r_result_mem;
    logic [WORD_W-1:0] r_instr_wb;
    logic [CTRL_W-1:0] r_ctrl_wb;
    logic [WORD_W-1:0] r_result_wb;
    logic [WORD_W-1:0] r_dmemload_wb;
    logic              r_halted;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic w_mem_stall;
    logic w_freeze;

    always_comb begin
        w_mem_stall = (r_ctrl_mem[1] | r_ctrl_mem[2]) & ~dhit & ~r_halted;
        w_freeze    = r_halted | w_mem_stall;
    end

    // Flush is tested before enable so a bubble always wins over a hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_instr_id <= '0;
        end else if (!w_freeze) begin
            if (flush_ID) begin
                r_instr_id <= '0;
            end else if (enable_ID) begin
                r_instr_id <= ihit ? instr_IF : '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_instr_ex <= '0;
            r_ctrl_ex  <= '0;
            r_data_ex  <= '0;
        end else if (!w_freeze) begin
            if (flush_EX) begin
                r_instr_ex <= '0;
                r_ctrl_ex  <= '0;
                r_data_ex  <= '0;
            end else if (enable_EX) begin
                r_instr_ex <= r_instr_id;
                r_ctrl_ex  <= ctrl_ID;
                r_data_ex  <= data_ID;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_instr_mem  <= '0;
            r_ctrl_mem   <= '0;
            r_result_mem <= '0;
        end else if (!w_freeze) begin
            if (flush_MEM) begin
                r_instr_mem  <= '0;
                r_ctrl_mem   <= '0;
                r_result_mem <= '0;
            end else if (enable_MEM) begin
                r_instr_mem  <= r_instr_ex;
                r_ctrl_mem   <= r_ctrl_ex;
                r_result_mem <= result_EX;
            end
        end
    end

    // A stalled memory access must not retire, so WB takes a bubble rather than holding.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_instr_wb    <= '0;
            r_ctrl_wb     <= '0;
            r_result_wb   <= '0;
            r_dmemload_wb <= '0;
        end else if (!r_halted) begin
            if (w_mem_stall) begin
                r_instr_wb    <= '0;
                r_ctrl_wb     <= '0;
                r_result_wb   <= '0;
                r_dmemload_wb <= '0;
            end else begin
                r_instr_wb    <= r_instr_mem;
                r_ctrl_wb     <= r_ctrl_mem;
                r_result_wb   <= r_result_mem;
                r_dmemload_wb <= dmemload_MEM;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_halted <= 1'b0;
        end else if (r_ctrl_wb[3]) begin
            r_halted <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cycles <= '0;
        end else if (!r_halted && (w_mem_stall || !enable_ID) && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign instr_ID     = r_instr_id;
    assign instr_EX     = r_instr_ex;
    assign instr_MEM    = r_instr_mem;
    assign instr_WB     = r_instr_wb;
    assign ctrl_EX      = r_ctrl_ex;
    assign ctrl_MEM     = r_ctrl_mem;
    assign ctrl_WB      = r_ctrl_wb;
    assign data_EX      = r_data_ex;
    assign result_MEM   = r_result_mem;
    assign result_WB    = r_result_wb;
    assign dmemload_WB  = r_dmemload_wb;
    assign RegWr_EX     = r_ctrl_ex[0];
    assign memWr_EX     = r_ctrl_ex[1];
    assign RegWr_MEM    = r_ctrl_mem[0];
    assign memWr_MEM    = r_ctrl_mem[1];
    assign mem_stall    = w_mem_stall;
    assign halted       = r_halted;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Scoreboard bench for pipe_stage_regs: a stage-slot model predicts every post-edge state,
// a separate monitor compares it against the DUT one step after each rising edge.
module tb_pipe_stage_regs;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit, dhit, flush_ID, flush_EX, flush_MEM, enable_ID, enable_EX, enable_MEM;
    logic [31:0] instr_IF, result_EX, dmemload_MEM;
    logic [7:0]  ctrl_ID;
    logic [95:0] data_ID;
    logic [31:0] instr_ID, instr_EX, instr_MEM, instr_WB, result_MEM, result_WB, dmemload_WB;
    logic [7:0]  ctrl_EX, ctrl_MEM, ctrl_WB;
    logic [95:0] data_EX;
    logic        RegWr_EX, memWr_EX, RegWr_MEM, memWr_MEM, mem_stall, halted;
    logic [15:0] stall_cycles;

    pipe_stage_regs dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_MEM(flush_MEM),
        .enable_ID(enable_ID), .enable_EX(enable_EX), .enable_MEM(enable_MEM),
        .instr_IF(instr_IF), .ctrl_ID(ctrl_ID), .data_ID(data_ID),
        .result_EX(result_EX), .dmemload_MEM(dmemload_MEM),
        .instr_ID(instr_ID), .instr_EX(instr_EX), .instr_MEM(instr_MEM), .instr_WB(instr_WB),
        .ctrl_EX(ctrl_EX), .ctrl_MEM(ctrl_MEM), .ctrl_WB(ctrl_WB), .data_EX(data_EX),
        .result_MEM(result_MEM), .result_WB(result_WB), .dmemload_WB(dmemload_WB),
        .RegWr_EX(RegWr_EX), .memWr_EX(memWr_EX), .RegWr_MEM(RegWr_MEM), .memWr_MEM(memWr_MEM),
        .mem_stall(mem_stall), .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  ctrl;
        logic [95:0] data;
        logic [31:0] result;
        logic [31:0] dml;
    } slot_t;

    typedef struct packed {
        slot_t       id;
        slot_t       ex;
        slot_t       mem;
        slot_t       wb;
        logic        hlt;
        logic [15:0] stall;
        logic        ms;
    } exp_t;

    exp_t  sb_q[$];
    slot_t m_st[4];
    logic  m_halted;
    int    m_stall;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_push = 0;
    int    n_pop = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_st[i] = '0;
        m_halted = 1'b0;
        m_stall  = 0;
    endtask

    task automatic safe_inputs();
        ihit = 1'b0; dhit = 1'b1;
        flush_ID = 1'b0; flush_EX = 1'b0; flush_MEM = 1'b0;
        enable_ID = 1'b1; enable_EX = 1'b1; enable_MEM = 1'b1;
        instr_IF = '0; ctrl_ID = '0; data_ID = '0; result_EX = '0; dmemload_MEM = '0;
    endtask

    // Drive one cycle of inputs and predict the state after the next rising edge.
    task automatic step(input logic ih, input logic dh, input logic fi, input logic fe,
                        input logic fm, input logic ei, input logic ee, input logic em,
                        input logic [31:0] ins, input logic [7:0] c, input logic [95:0] d,
                        input logic [31:0] r, input logic [31:0] dm);
        slot_t o[4];
        logic  ms;
        exp_t  e;
        @(negedge CLK);
        ihit = ih; dhit = dh; flush_ID = fi; flush_EX = fe; flush_MEM = fm;
        enable_ID = ei; enable_EX = ee; enable_MEM = em;
        instr_IF = ins; ctrl_ID = c; data_ID = d; result_EX = r; dmemload_MEM = dm;
        o  = m_st;
        ms = (m_st[2].ctrl[1] | m_st[2].ctrl[2]) & ~dh & ~m_halted;
        if (!m_halted) begin
            if (ms || !ei) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
            if (!ms) begin
                if (fi) o[0] = '0;
                else if (ei) begin
                    o[0] = '0;
                    if (ih) o[0].instr = ins;
                end
                if (fe) o[1] = '0;
                else if (ee) begin
                    o[1] = '0;
                    o[1].instr = m_st[0].instr;
                    o[1].ctrl  = c;
                    o[1].data  = d;
                end
                if (fm) o[2] = '0;
                else if (em) begin
                    o[2] = '0;
                    o[2].instr  = m_st[1].instr;
                    o[2].ctrl   = m_st[1].ctrl;
                    o[2].result = r;
                end
                o[3]      = m_st[2];
                o[3].data = '0;
                o[3].dml  = dm;
            end else begin
                o[3] = '0;
            end
            if (m_st[3].ctrl[3]) m_halted = 1'b1;
            m_st = o;
        end
        e.id    = m_st[0];
        e.ex    = m_st[1];
        e.mem   = m_st[2];
        e.wb    = m_st[3];
        e.hlt   = m_halted;
        e.stall = m_stall[15:0];
        e.ms    = (m_st[2].ctrl[1] | m_st[2].ctrl[2]) & ~dh & ~m_halted;
        sb_q.push_back(e);
        n_push++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_instr_ID"}, 128'(instr_ID), 128'd0);
        chk({tag, "_instr_EX"}, 128'(instr_EX), 128'd0);
        chk({tag, "_instr_MEM"}, 128'(instr_MEM), 128'd0);
        chk({tag, "_instr_WB"}, 128'(instr_WB), 128'd0);
        chk({tag, "_ctrl"}, 128'({ctrl_EX, ctrl_MEM, ctrl_WB}), 128'd0);
        chk({tag, "_data_EX"}, 128'(data_EX), 128'd0);
        chk({tag, "_results"}, 128'({result_MEM, result_WB, dmemload_WB}), 128'd0);
        chk({tag, "_halted"}, 128'(halted), 128'd0);
        chk({tag, "_stall_cycles"}, 128'(stall_cycles), 128'd0);
    endtask

    // Asynchronous reset pulse in the middle of the low clock phase.
    task automatic mid_reset();
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_all_zero("midrst");
        safe_inputs();
        model_reset();
        #1 RST = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_pop++;
                chk("instr_ID", 128'(instr_ID), 128'(e.id.instr));
                chk("instr_EX", 128'(instr_EX), 128'(e.ex.instr));
                chk("ctrl_EX", 128'(ctrl_EX), 128'(e.ex.ctrl));
                chk("data_EX", 128'(data_EX), 128'(e.ex.data));
                chk("instr_MEM", 128'(instr_MEM), 128'(e.mem.instr));
                chk("ctrl_MEM", 128'(ctrl_MEM), 128'(e.mem.ctrl));
                chk("result_MEM", 128'(result_MEM), 128'(e.mem.result));
                chk("instr_WB", 128'(instr_WB), 128'(e.wb.instr));
                chk("ctrl_WB", 128'(ctrl_WB), 128'(e.wb.ctrl));
                chk("result_WB", 128'(result_WB), 128'(e.wb.result));
                chk("dmemload_WB", 128'(dmemload_WB), 128'(e.wb.dml));
                chk("hazard_bits", 128'({RegWr_EX, memWr_EX, RegWr_MEM, memWr_MEM}),
                    128'({e.ex.ctrl[0], e.ex.ctrl[1], e.mem.ctrl[0], e.mem.ctrl[1]}));
                chk("mem_stall", 128'(mem_stall), 128'(e.ms));
                chk("halted", 128'(halted), 128'(e.hlt));
                chk("stall_cycles", 128'(stall_cycles), 128'(e.stall));
            end
        end
    end

    initial begin : stimulus
        logic [7:0] c;
        safe_inputs();
        model_reset();
        #3 check_all_zero("rst");
        @(negedge CLK);
        RST = 1'b0;

        // Straight flow of a load, then a 3-cycle data-cache miss on it.
        step(1, 1, 0, 0, 0, 1, 1, 1, 32'h8C220004, 8'h00, 96'h0, 32'h0, 32'h0);
        step(0, 1, 0, 0, 0, 1, 1, 1, 32'h0, 8'h05, 96'h1111_2222_3333, 32'h0, 32'h0);
        step(0, 1, 0, 0, 0, 1, 1, 1, 32'h0, 8'h00, 96'h0, 32'h100, 32'h0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 1, 1, 1, 32'h00430820, 8'h01, 96'h5, 32'h200, 32'h77);
        step(1, 1, 0, 0, 0, 1, 1, 1, 32'h00430820, 8'h01, 96'h5, 32'h200, 32'hDEADBEEF);
        // Load-use stall: hold ID, bubble EX, then release.
        step(1, 1, 0, 0, 0, 1, 1, 1, 32'h8C640000, 8'h01, 96'h6, 32'h300, 32'h0);
        step(1, 1, 0, 1, 0, 0, 1, 1, 32'h12345678, 8'h05, 96'h7, 32'h400, 32'h0);
        step(1, 1, 0, 0, 0, 1, 1, 1, 32'h12345678, 8'h05, 96'h8, 32'h500, 32'h0);
        step(1, 1, 0, 0, 0, 1, 1, 1, 32'h08000010, 8'h01, 96'h9, 32'h600, 32'h0);
        // Jump: every flush together, with enable_EX low.
        step(1, 1, 1, 1, 1, 1, 0, 1, 32'hAAAA5555, 8'h01, 96'hA, 32'h700, 32'h0);
        step(1, 1, 0, 0, 0, 1, 1, 1, 32'h20010001, 8'h01, 96'hB, 32'h800, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            c = 8'($urandom) & 8'hF7;
            step(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) != 0),
                 ($urandom_range(0, 6) != 0), ($urandom_range(0, 6) != 0),
                 $urandom, c, {$urandom, $urandom, $urandom}, $urandom, $urandom);
        end

        // Halt propagates, then everything freezes under random inputs.
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 0, 0, 1, 1, 1, 32'h0, 8'h00, 96'h0, 32'h0, 32'h0);
        step(1, 1, 0, 0, 0, 1, 1, 1, 32'hFC000000, 8'h00, 96'h0, 32'h0, 32'h0);
        step(1, 1, 0, 0, 0, 1, 1, 1, 32'h00000000, 8'h08, 96'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 0, 0, 1, 1, 1, 32'h11110000 + i, 8'h01, 96'h0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom, 8'($urandom), {$urandom, $urandom, $urandom}, $urandom, $urandom);
        chk("halt_reached", 128'(halted), 128'd1);

        mid_reset();

        // Counter saturation.
        for (int i = 0; i < 70000; i++)
            step(0, 1, 0, 0, 0, 0, 1, 1, 32'h0, 8'h00, 96'h0, 32'h0, 32'h0);
        @(posedge CLK);
        #2;
        chk("stall_saturated", 128'(stall_cycles), 128'h0000_FFFF);
        chk("sb_drained", 128'(sb_q.size()), 128'd0);
        chk("sb_count", 128'(n_pop), 128'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
